// File: rtl/aes256_pkg.sv
// Shared AES-256 constants, FSM encoding and the GF(2^8) primitives used by the
// key schedule and the inverse round functions.
package aes256_pkg;

    localparam int unsigned AesNr    = 14;
    localparam int unsigned BlockW   = 128;
    localparam int unsigned KeyW     = 256;
    localparam int unsigned SchedW   = 1920;
    localparam int unsigned NumWords = SchedW / 32;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StLast,
        StDone
    } state_e;

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round key r lives at [r*128 +: 128] with word 4r in its most significant 32 bits.
    function automatic logic [SchedW-1:0] key_expansion_256(input logic [KeyW-1:0] key);
        logic [31:0]       w [NumWords];
        logic [SchedW-1:0] sched;
        logic [31:0]       tmp;
        logic [7:0]        rcon;
        rcon  = 8'h01;
        sched = '0;
        for (int i = 0; i < 8; i++) begin
            w[i] = key[KeyW-1-32*i -: 32];
        end
        for (int i = 8; i < int'(NumWords); i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < int'(NumWords); i++) begin
            sched[(i / 4) * 128 + (3 - i % 4) * 32 +: 32] = w[i];
        end
        return sched;
    endfunction

    // Byte k of a block sits at [BlockW-1-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [BlockW-1:0] inv_shift_rows(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[BlockW-1-8*(4*c+r) -: 8] = s[BlockW-1-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BlockW-1:0] inv_sub_bytes(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[BlockW-1-8*k -: 8] = inv_sbox(s[BlockW-1-8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [BlockW-1:0] inv_mix_columns(input logic [BlockW-1:0] s);
        logic [BlockW-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[BlockW-1-32*c -: 8];
            a1 = s[BlockW-9-32*c -: 8];
            a2 = s[BlockW-17-32*c -: 8];
            a3 = s[BlockW-25-32*c -: 8];
            o[BlockW-1-32*c -: 8]  = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                   ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[BlockW-9-32*c -: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                   ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[BlockW-17-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                   ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[BlockW-25-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                   ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [BlockW-1:0] round_inverse(input logic [BlockW-1:0] s,
                                                        input logic [BlockW-1:0] rk);
        return inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ rk);
    endfunction

    function automatic logic [BlockW-1:0] last_round_inv(input logic [BlockW-1:0] s,
                                                         input logic [BlockW-1:0] rk);
        return inv_sub_bytes(inv_shift_rows(s)) ^ rk;
    endfunction

endpackage

// File: rtl/aes256_inv_round_mux.sv
// Picks rk[rcnt] (or rk[0] on the final step) from the schedule and applies the
// matching inverse round to the working state.
module aes256_inv_round_mux
    import aes256_pkg::*;
(
    input  logic [BlockW-1:0] state_i,
    input  logic [SchedW-1:0] sched_i,
    input  logic [3:0]        rcnt_i,
    input  logic              last_i,
    output logic [BlockW-1:0] result_o
);

    logic [BlockW-1:0] rk;

    always_comb begin
        rk = sched_i[0 +: BlockW];
        if (!last_i) begin
            for (int r = 1; r <= int'(AesNr); r++) begin
                if (rcnt_i == 4'(r)) rk = sched_i[r*BlockW +: BlockW];
            end
        end
    end

    assign result_o = last_i ? last_round_inv(state_i, rk) : round_inverse(state_i, rk);

endmodule

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher: one round per clock, valid/ready on both sides,
// plaintext held in DONE until the consumer takes it.
module aes256_decrypt_core
    import aes256_pkg::*;
#(
    parameter int unsigned NR = AesNr
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KeyW-1:0]   key,
    input  logic [BlockW-1:0] ct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BlockW-1:0] pt
);

    state_e            fsm_q, fsm_d;
    logic [BlockW-1:0] state_q, state_d;
    logic [BlockW-1:0] pt_q, pt_d;
    logic [KeyW-1:0]   key_q, key_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              out_valid_q, out_valid_d;

    logic [KeyW-1:0]   key_sel;
    logic [SchedW-1:0] sched;
    logic [BlockW-1:0] rk_first;
    logic [BlockW-1:0] round_res;

    // The accepting edge needs rk[NR] before key_q is loaded, so IDLE expands the port key.
    assign key_sel  = (fsm_q == StIdle) ? key : key_q;
    assign sched    = key_expansion_256(key_sel);
    assign rk_first = sched[NR*BlockW +: BlockW];

    aes256_inv_round_mux u_round_mux (
        .state_i  (state_q),
        .sched_i  (sched),
        .rcnt_i   (rcnt_q),
        .last_i   (fsm_q == StLast),
        .result_o (round_res)
    );

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = out_valid_q;
    assign pt        = pt_q;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        rcnt_d      = rcnt_q;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    key_d   = key;
                    state_d = ct ^ rk_first;
                    rcnt_d  = 4'(NR - 1);
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                state_d = round_res;
                if (rcnt_q <= 4'd1) begin
                    rcnt_d = '0;
                    fsm_d  = StLast;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            StLast: begin
                pt_d        = round_res;
                out_valid_d = 1'b1;
                fsm_d       = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            rcnt_q      <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            rcnt_q      <= rcnt_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
